// File: rtl/btn_conditioner_if.sv
// Button bundle between the raw pads and the debounced outputs of btn_conditioner.
// The conditioner takes the slave side; the master side drives the pads and observes the outputs.
interface btn_conditioner_if #(
  parameter int unsigned NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_event;
  logic [NUM_BTN-1:0] btn_held;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_event,
    input  btn_held
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_event,
    output btn_held
  );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce, press event with auto-repeat while held.
// Auto-repeat and btn_held are built only when AUTOREPEAT_EN is defined.
module btn_conditioner #(
  parameter int unsigned NUM_BTN        = 4,
  parameter int unsigned DEBOUNCE_CYC   = 500000,
  parameter int unsigned HOLD_CYC       = 25000000,
  parameter int unsigned REPEAT_CYC     = 5000000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input logic              clk,
  input logic              RST,
  btn_conditioner_if.slave btn
);
  localparam int unsigned        DEB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [NUM_BTN-1:0] RELEASED = {NUM_BTN{BTN_ACTIVE_LOW}};

`ifdef AUTOREPEAT_EN
  localparam int unsigned HOLD_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;
`else
  typedef enum logic {IDLE, PRESSED} state_t;
`endif

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] pressed;

  // Synchronisers reset to the released pad level so reset never looks like a press.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= btn.btn_raw;
      sync2 <= sync1;
    end
  end

  assign pressed = BTN_ACTIVE_LOW ? ~sync2 : sync2;

  for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_ch
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_nxt;
    logic             level_q;
    logic             level_nxt;
    logic             event_q;
    state_t           state;

    // Level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
    always_comb begin
      level_nxt = level_q;
      deb_nxt   = '0;
      if (pressed[i] != level_q) begin
        if (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
          level_nxt = ~level_q;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
        deb_cnt <= '0;
        level_q <= 1'b0;
      end else begin
        deb_cnt <= deb_nxt;
        level_q <= level_nxt;
      end
    end

`ifdef AUTOREPEAT_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic              held_q;

    // FSM follows level_nxt so the press pulse lands in the first cycle btn_level reads 1
    // and a release always wins over a coincident repeat.
    always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
        state    <= IDLE;
        hold_cnt <= '0;
        event_q  <= 1'b0;
        held_q   <= 1'b0;
      end else begin
        event_q <= 1'b0;
        held_q  <= 1'b0;
        if (!level_nxt) begin
          state    <= IDLE;
          hold_cnt <= '0;
        end else begin
          case (state)
            IDLE: begin
              event_q  <= 1'b1;
              state    <= PRESSED;
              hold_cnt <= '0;
            end
            PRESSED: begin
              if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                event_q  <= 1'b1;
                state    <= REPEAT;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            REPEAT: begin
              held_q <= 1'b1;
              if (hold_cnt == HOLD_W'(REPEAT_CYC - 1)) begin
                event_q  <= 1'b1;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            default: begin
              state    <= IDLE;
              hold_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign btn.btn_held[i] = held_q;
`else
    // Single pulse per accepted press; no repeat timing.
    always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
        state   <= IDLE;
        event_q <= 1'b0;
      end else begin
        event_q <= 1'b0;
        if (!level_nxt) begin
          state <= IDLE;
        end else if (state == IDLE) begin
          event_q <= 1'b1;
          state   <= PRESSED;
        end
      end
    end

    assign btn.btn_held[i] = 1'b0;
`endif

    assign btn.btn_level[i] = level_q;
    assign btn.btn_event[i] = event_q;
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short debounce/hold/repeat timings.
// Expected outputs per cycle are queued when a scenario starts and popped as the DUT runs.
module tb_btn_conditioner;
  localparam int unsigned NB   = 4;
  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 10;
  localparam int unsigned REP  = 3;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] r;

  btn_conditioner_if #(.NUM_BTN(NB)) bif ();

  btn_conditioner #(
    .NUM_BTN       (NB),
    .DEBOUNCE_CYC  (DEB),
    .HOLD_CYC      (HOLD),
    .REPEAT_CYC    (REP),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .RST(rst),
    .btn(bif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  level;
    logic [3:0]  evt;
    logic [3:0]  held;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  press;
    int unsigned rel;
    int unsigned ncyc;
    int unsigned lvl_on;
    int unsigned lvl_off;
    int unsigned held_on;
    int unsigned nev;
    int unsigned ev[8];
  } scn_t;

  exp_t exp_q[$];
  scn_t tbl[3];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string name, input int unsigned c, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b want %b", name, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string name, input int unsigned c);
    exp_t e;
    if (exp_q.size() != 0 && exp_q[0].cyc == c) begin
      e = exp_q.pop_front();
      cmp({name, ".level"}, c, bif.btn_level, e.level);
      cmp({name, ".event"}, c, bif.btn_event, e.evt);
      cmp({name, ".held"},  c, bif.btn_held,  e.held);
    end
  endtask

  task automatic drain(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s scoreboard: got %0d unchecked entries want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    exp_t e;
    scn_t s;

    tbl[0] = '{name:"clean", press:4'b0001, rel:8, ncyc:18, lvl_on:6, lvl_off:14,
               held_on:0, nev:1, ev:'{6, 0, 0, 0, 0, 0, 0, 0}};
    // Release lands exactly where the first repeat would fire: no pulse at 16.
    tbl[1] = '{name:"simult", press:4'b1001, rel:10, ncyc:20, lvl_on:6, lvl_off:16,
               held_on:0, nev:1, ev:'{6, 0, 0, 0, 0, 0, 0, 0}};
`ifdef AUTOREPEAT_EN
    tbl[2] = '{name:"repeat", press:4'b0100, rel:28, ncyc:38, lvl_on:6, lvl_off:34,
               held_on:17, nev:7, ev:'{6, 16, 19, 22, 25, 28, 31, 0}};
`else
    tbl[2] = '{name:"repeat", press:4'b0100, rel:28, ncyc:38, lvl_on:6, lvl_off:34,
               held_on:0, nev:1, ev:'{6, 0, 0, 0, 0, 0, 0, 0}};
`endif

    bif.btn_raw = 4'hF;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();
    cmp("reset.level", 0, bif.btn_level, 4'h0);
    cmp("reset.event", 0, bif.btn_event, 4'h0);
    cmp("reset.held",  0, bif.btn_held,  4'h0);
    rst = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 3; i++) begin
      s = tbl[i];
      for (int unsigned c = 0; c < s.ncyc; c++) begin
        e.cyc   = c;
        e.level = (c >= s.lvl_on && c < s.lvl_off) ? s.press : 4'h0;
        e.held  = (s.held_on != 0 && c >= s.held_on && c < s.lvl_off) ? s.press : 4'h0;
        e.evt   = 4'h0;
        for (int unsigned k = 0; k < s.nev; k++) if (s.ev[k] == c) e.evt = s.press;
        exp_q.push_back(e);
      end
      for (int unsigned c = 0; c < s.ncyc; c++) begin
        check_cycle(s.name, c);
        bif.btn_raw = (c < s.rel) ? ~s.press : 4'hF;
        tick();
      end
      drain(s.name);
    end

    // Bounce: raw[1] toggles every 2 cycles, never stable long enough to be accepted.
    for (int unsigned c = 0; c < 30; c++) begin
      e.cyc = c; e.level = 4'h0; e.evt = 4'h0; e.held = 4'h0;
      exp_q.push_back(e);
    end
    for (int unsigned c = 0; c < 30; c++) begin
      check_cycle("bounce", c);
      r = 4'hF;
      if (c < 20 && ((c / 2) % 2 == 0)) r[1] = 1'b0;
      bif.btn_raw = r;
      tick();
    end
    drain("bounce");

    // Reset while channel 2 is held, then a fresh debounce and press event.
    for (int unsigned c = 0; c < 42; c++) begin
      e.cyc   = c;
      e.level = ((c >= 6 && c <= 18) || (c >= 26 && c < 36)) ? 4'b0100 : 4'h0;
`ifdef AUTOREPEAT_EN
      e.evt   = (c == 6 || c == 16 || c == 26) ? 4'b0100 : 4'h0;
      e.held  = (c == 17 || c == 18) ? 4'b0100 : 4'h0;
`else
      e.evt   = (c == 6 || c == 26) ? 4'b0100 : 4'h0;
      e.held  = 4'h0;
`endif
      exp_q.push_back(e);
    end
    for (int unsigned c = 0; c < 42; c++) begin
      check_cycle("rsthold", c);
      if (c == 18) begin
        rst = 1'b0;
        #1;
        cmp("rst_async.level", c, bif.btn_level, 4'h0);
        cmp("rst_async.event", c, bif.btn_event, 4'h0);
        cmp("rst_async.held",  c, bif.btn_held,  4'h0);
      end
      if (c == 20) rst = 1'b1;
      bif.btn_raw = (c < 30) ? 4'b1011 : 4'hF;
      tick();
    end
    drain("rsthold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
